// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter sharing one line-wide memory port between an I-cache and a D-cache.
// Requests are latched on grant so the memory payload stays stable for the whole transaction.

module cache_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic grant_d,
  input logic d_read,
  input logic d_write,
  input logic mem_read,
  input logic mem_write
);

  // Memory strobes are mutually exclusive.
  strobe_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(mem_read && mem_write));

  // A D-side request carrying both ops is served as a write, but is still a client bug.
  d_op_exclusive: assert property (@(posedge clk) disable iff (rst)
    grant_d |-> !(d_read && d_write));

endmodule

module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_SERVE = 2'd1,
    D_SERVE = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state_r;
  state_t            state_s;
  logic              last_grant_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              write_op_r;
  logic              grant_i_s;
  logic              grant_d_s;
  logic              d_req_s;

  assign d_req_s     = d_read | d_write;
  assign mem_address = addr_r;
  assign mem_wdata   = wdata_r;
  // Return data bypasses straight from memory; forced low only while reset is held.
  assign i_rdata     = rst ? {LINE_W{1'b0}} : mem_rdata;
  assign d_rdata     = rst ? {LINE_W{1'b0}} : mem_rdata;

  // Next-state, grant decision and memory/response strobes.
  always_comb begin
    state_s   = state_r;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_read && d_req_s) begin
          // Tie: the side that did not win last time goes first.
          if (last_grant_r == GRANT_I) begin
            grant_d_s = 1'b1;
          end else begin
            grant_i_s = 1'b1;
          end
        end else if (i_read) begin
          grant_i_s = 1'b1;
        end else if (d_req_s) begin
          grant_d_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
        end
        if (grant_i_s) begin
          state_s = I_SERVE;
        end else if (grant_d_s) begin
          state_s = D_SERVE;
        end else begin
          state_s = IDLE;
        end
      end
      I_SERVE: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          i_resp  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = I_SERVE;
        end
      end
      D_SERVE: begin
        mem_read  = ~write_op_r;
        mem_write = write_op_r;
        if (mem_resp) begin
          d_resp  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = D_SERVE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, round-robin pointer and latched request payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_I;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {LINE_W{1'b0}};
      write_op_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (grant_i_s) begin
        last_grant_r <= GRANT_I;
        addr_r       <= i_address;
        write_op_r   <= 1'b0;
      end else if (grant_d_s) begin
        last_grant_r <= GRANT_D;
        addr_r       <= d_address;
        wdata_r      <= d_wdata;
        write_op_r   <= d_write;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  cache_arbiter_checker u_checker (
    .clk       (clk),
    .rst       (rst),
    .grant_d   (grant_d_s),
    .d_read    (d_read),
    .d_write   (d_write),
    .mem_read  (mem_read),
    .mem_write (mem_write)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus random traffic against a transaction-level model
// that tracks who owns the memory port and what payload it was granted with.

module tb_cache_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: owner 0 = nobody, 1 = I-cache, 2 = D-cache; last = side granted most recently.
  int                m_owner;
  int                m_last;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic              m_wr;
  logic              i_done;
  logic              d_done;

  task automatic check_val(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called just after the negedge with inputs already driven; checks this cycle, advances the model
  // using the inputs present at the coming posedge, then returns at the following negedge.
  task automatic step();
    logic exp_mr, exp_mw, exp_ir, exp_dr;
    logic want_i, want_d;
    int   pick;
    #1;
    if (rst) begin
      m_owner = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
    end
    exp_mr = (m_owner == 1) || (m_owner == 2 && !m_wr);
    exp_mw = (m_owner == 2) && m_wr;
    exp_ir = (m_owner == 1) && mem_resp && !rst;
    exp_dr = (m_owner == 2) && mem_resp && !rst;
    check_val("mem_read", {255'd0, mem_read}, {255'd0, exp_mr});
    check_val("mem_write", {255'd0, mem_write}, {255'd0, exp_mw});
    check_val("i_resp", {255'd0, i_resp}, {255'd0, exp_ir});
    check_val("d_resp", {255'd0, d_resp}, {255'd0, exp_dr});
    if (rst) begin
      check_val("rst_mem_address", {224'd0, mem_address}, 256'd0);
      check_val("rst_mem_wdata", mem_wdata, 256'd0);
      check_val("rst_i_rdata", i_rdata, 256'd0);
      check_val("rst_d_rdata", d_rdata, 256'd0);
    end
    if (m_owner != 0) check_val("mem_address", {224'd0, mem_address}, {224'd0, m_addr});
    if (m_owner == 2) check_val("mem_wdata", mem_wdata, m_wdata);
    if (exp_ir) check_val("i_rdata", i_rdata, mem_rdata);
    if (exp_dr) check_val("d_rdata", d_rdata, mem_rdata);
    i_done = exp_ir;
    d_done = exp_dr;
    if (!rst) begin
      if (m_owner != 0) begin
        if (mem_resp) m_owner = 0;
      end else begin
        want_i = i_read;
        want_d = d_read | d_write;
        pick = 0;
        if (want_i && want_d) pick = (m_last == 1) ? 2 : 1;
        else if (want_i) pick = 1;
        else if (want_d) pick = 2;
        if (pick == 1) begin
          m_addr = i_address; m_wr = 1'b0;
        end else if (pick == 2) begin
          m_addr = d_address; m_wdata = d_wdata; m_wr = d_write;
        end
        if (pick != 0) begin
          m_owner = pick; m_last = pick;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
  endtask

  logic i_pend, d_pend, d_is_wr;

  initial begin
    m_owner = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
    i_done = 1'b0; d_done = 1'b0;
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    step();

    // I-cache fill, memory answers after 4 cycles.
    idle_inputs();
    i_read = 1'b1; i_address = 32'h0000_1000;
    step();
    for (int k = 0; k < 4; k++) begin
      i_address = 32'h0000_7000 + k;
      #1 check_val("fill_addr_held", {224'd0, mem_address}, {224'd0, 32'h0000_1000});
      step();
    end
    mem_resp = 1'b1; mem_rdata = {32{8'hA5}};
    #1 check_val("fill_i_rdata", i_rdata, {32{8'hA5}});
    check_val("fill_i_resp", {255'd0, i_resp}, 256'd1);
    step();
    idle_inputs();
    step();

    // D-cache writeback.
    d_write = 1'b1; d_address = 32'h0000_2040; d_wdata = {8{32'h1234_5678}};
    step();
    #1 check_val("wb_mem_write", {255'd0, mem_write}, 256'd1);
    check_val("wb_mem_wdata", mem_wdata, {8{32'h1234_5678}});
    step();
    mem_resp = 1'b1;
    step();
    idle_inputs();
    step();

    // Tie straight out of reset: D first, then I one cycle after d_resp.
    rst = 1'b1;
    step();
    idle_inputs();
    i_read = 1'b1; i_address = 32'h0000_1000; d_read = 1'b1; d_address = 32'h0000_2040;
    step();
    #1 check_val("tie_d_first", {224'd0, mem_address}, {224'd0, 32'h0000_2040});
    mem_resp = 1'b1;
    step();
    d_read = 1'b0; mem_resp = 1'b0;
    step();
    #1 check_val("tie_i_second", {224'd0, mem_address}, {224'd0, 32'h0000_1000});
    mem_resp = 1'b1;
    step();
    idle_inputs();
    step();

    // Reset during a D transaction aborts it; next tie again goes to D.
    d_read = 1'b1; d_address = 32'h0000_3080;
    step();
    step();
    rst = 1'b1;
    #1 check_val("abort_strobe", {255'd0, mem_read}, 256'd0);
    step();
    idle_inputs();
    i_read = 1'b1; i_address = 32'h0000_1000; d_read = 1'b1; d_address = 32'h0000_3080;
    step();
    #1 check_val("post_rst_tie_d", {224'd0, mem_address}, {224'd0, 32'h0000_3080});
    mem_resp = 1'b1;
    step();
    d_read = 1'b0; mem_resp = 1'b0;
    step();
    mem_resp = 1'b1;
    step();
    idle_inputs();

    // Stray memory responses while idle are ignored.
    mem_resp = 1'b1;
    step();
    step();
    mem_resp = 1'b0;
    step();

    // Random traffic.
    i_pend = 1'b0; d_pend = 1'b0; d_is_wr = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (i_done) i_pend = 1'b0;
      if (d_done) d_pend = 1'b0;
      rst = ($urandom_range(0, 249) == 0);
      if (!i_pend && $urandom_range(0, 3) == 0) begin
        i_pend = 1'b1;
        i_address = $urandom & 32'hFFFF_FFE0;
      end else if (i_pend && m_owner == 1) begin
        i_address = $urandom;
      end
      i_read = i_pend;
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        d_pend = 1'b1;
        d_is_wr = $urandom_range(0, 1) == 1;
        d_address = $urandom & 32'hFFFF_FFE0;
        d_wdata = rand_line();
      end else if (d_pend && m_owner == 2) begin
        d_address = $urandom;
        d_wdata = rand_line();
      end
      d_read = d_pend && !d_is_wr;
      d_write = d_pend && d_is_wr;
      mem_resp = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      mem_rdata = rand_line();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
